// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with a req/ack data port, big-endian sub-word alignment,
// pipeline freeze while an access is outstanding, and an access timeout.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] aluResult1_EX,
  input  logic [31:0] readDataB1_EX,
  input  logic [31:0] Instr1_EX,
  input  logic [4:0]  writeRegister1_EX,
  input  logic        do_writeback1_EX,
  input  logic        MemRead1_EX,
  input  logic        MemWrite1_EX,
  input  logic        MemtoReg1_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        FREEZE,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic [31:0] Data1_PR,
  output logic [4:0]  writeRegister1_PR,
  output logic        do_writeback1_PR,
  output logic        mem_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, tout_q, tout_d, err_q, err_d, wb_q, wb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d, data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  wr_q, wr_d;
  logic [5:0]  op;
  logic [1:0]  a;
  logic        is_byte, is_half, is_signed, is_load, mem_op, misal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_align;
  logic        unused;
  assign unused    = ^Instr1_EX[25:0];
  assign op        = Instr1_EX[31:26];
  assign a         = aluResult1_EX[1:0];
  assign is_byte   = op inside {6'h20, 6'h24, 6'h28};
  assign is_half   = op inside {6'h21, 6'h25, 6'h29};
  assign is_signed = op inside {6'h20, 6'h21};
  assign is_load   = MemRead1_EX & ~MemWrite1_EX;
  assign mem_op    = MemRead1_EX | MemWrite1_EX;
  assign misal     = is_half ? a[0] : (!is_byte && a != 2'b00);
  // big-endian: lane 0 is the most significant byte
  assign lane_b    = 8'(dmem_rdata >> {~a, 3'b000});
  assign lane_h    = a[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
  assign ld_align  = is_byte ? {{24{is_signed & lane_b[7]}}, lane_b} :
                     is_half ? {{16{is_signed & lane_h[15]}}, lane_h} : dmem_rdata;
  assign FREEZE             = (state_q == S_WAIT) || (state_q == S_IDLE && mem_op && !misal);
  assign Data1_MEM          = aluResult1_EX;
  assign writeRegister1_MEM = writeRegister1_EX;
  assign do_writeback1_MEM  = do_writeback1_EX & ~MemRead1_EX;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign Data1_PR          = data_q;
  assign writeRegister1_PR = wr_q;
  assign do_writeback1_PR  = wb_q;
  assign mem_err           = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    tout_d  = tout_q;
    err_d   = 1'b0;
    data_d  = data_q;
    wr_d    = wr_q;
    wb_d    = wb_q;
    case (state_q)
      S_IDLE: begin
        data_d = aluResult1_EX;
        wr_d   = writeRegister1_EX;
        wb_d   = do_writeback1_EX & ~mem_op;
        err_d  = mem_op & misal;
        if (mem_op && !misal) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = MemWrite1_EX;
          addr_d  = {aluResult1_EX[31:2], 2'b00};
          be_d    = is_byte ? 4'b1000 >> a : is_half ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
          wdata_d = is_byte ? {4{readDataB1_EX[7:0]}} :
                    is_half ? {2{readDataB1_EX[15:0]}} : readDataB1_EX;
          tout_d  = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // ack takes priority over a coincident timeout
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = ld_align;
        end else if (cnt_q == TLIM) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          tout_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        data_d  = (is_load && MemtoReg1_EX && !tout_q) ? ld_q : aluResult1_EX;
        wr_d    = writeRegister1_EX;
        wb_d    = do_writeback1_EX & ~MemWrite1_EX & ~tout_q;
        tout_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      wr_q    <= '0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      wb_q    <= wb_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized checks of mem_stage against a big-endian load/store reference model.
module tb_mem_stage;
  localparam int TO = 4;
  logic CLK = 1'b0, RESET = 1'b0;
  logic [31:0] aluResult1_EX, readDataB1_EX, Instr1_EX, dmem_rdata;
  logic [4:0]  writeRegister1_EX;
  logic do_writeback1_EX, MemRead1_EX, MemWrite1_EX, MemtoReg1_EX, dmem_ack;
  logic dmem_req, dmem_we, FREEZE, do_writeback1_MEM, do_writeback1_PR, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, Data1_MEM, Data1_PR;
  logic [3:0]  dmem_be;
  logic [4:0]  writeRegister1_MEM, writeRegister1_PR;
  int checks = 0, errors = 0;
  mem_stage #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .aluResult1_EX(aluResult1_EX), .readDataB1_EX(readDataB1_EX),
    .Instr1_EX(Instr1_EX), .writeRegister1_EX(writeRegister1_EX), .do_writeback1_EX(do_writeback1_EX),
    .MemRead1_EX(MemRead1_EX), .MemWrite1_EX(MemWrite1_EX), .MemtoReg1_EX(MemtoReg1_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .FREEZE(FREEZE),
    .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM), .do_writeback1_MEM(do_writeback1_MEM),
    .Data1_PR(Data1_PR), .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
    .mem_err(mem_err));
  always #5 CLK = ~CLK;
  function automatic int size_of(logic [5:0] op);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 4;
  endfunction
  function automatic logic [31:0] exp_load(logic [5:0] op, logic [31:0] addr, logic [31:0] rd);
    int k = int'(addr % 4);
    logic [31:0] v;
    bit sgn = (op == 6'h20 || op == 6'h21);
    if (size_of(op) == 1) begin
      v = (rd >> (8 * (3 - k))) & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
      return v;
    end
    if (size_of(op) == 2) begin
      v = (rd >> (16 * (1 - k / 2))) & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
      return v;
    end
    return rd;
  endfunction
  function automatic logic [3:0] exp_be(logic [5:0] op, logic [31:0] addr);
    int k = int'(addr % 4);
    if (size_of(op) == 1) return 4'(8 >> k);
    if (size_of(op) == 2) return (k < 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction
  function automatic logic [31:0] exp_wdata(logic [5:0] op, logic [31:0] d);
    if (size_of(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size_of(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction
  task automatic set_in(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] wr, input logic wb, input logic rd, input logic wrt);
    Instr1_EX = instr; aluResult1_EX = alu; readDataB1_EX = b; writeRegister1_EX = wr;
    do_writeback1_EX = wb; MemRead1_EX = rd; MemWrite1_EX = wrt; MemtoReg1_EX = rd & ~wrt;
  endtask
  task automatic set_nop();
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    logic [31:0] r = $urandom;
    set_in({6'h00, 26'($urandom)}, r, $urandom, 5'd9, 1'b1, 1'b0, 1'b0);
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, Data1_PR, writeRegister1_PR, do_writeback1_PR, mem_err} !== '0) begin
      errors++; $display("FAIL reset_regs: req=%b addr=%h PR=%h wb=%b err=%b required all zero", dmem_req, dmem_addr, Data1_PR, do_writeback1_PR, mem_err);
    end
    checks++;
    if (Data1_MEM !== r || writeRegister1_MEM !== 5'd9 || do_writeback1_MEM !== 1'b1) begin
      errors++; $display("FAIL reset_taps: got %h/%0d/%b required %h/9/1", Data1_MEM, writeRegister1_MEM, do_writeback1_MEM, r);
    end
    set_nop();
    RESET = 1'b1;
    @(negedge CLK);
  endtask
  task automatic test_alu(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] r = (i == 0) ? 32'h1234 : $urandom;
      logic [4:0]  w = (i == 0) ? 5'd5 : 5'($urandom);
      logic        b = (i == 0) ? 1'b1 : 1'($urandom);
      set_in({6'h00, 26'($urandom)}, r, $urandom, w, b, 1'b0, 1'b0);
      #1;
      checks++;
      if (FREEZE !== 1'b0 || Data1_MEM !== r || do_writeback1_MEM !== b) begin
        errors++; $display("FAIL alu_taps: FREEZE=%b MEM=%h wbm=%b required 0/%h/%b", FREEZE, Data1_MEM, do_writeback1_MEM, r, b);
      end
      @(negedge CLK);
      checks++;
      if (Data1_PR !== r || writeRegister1_PR !== w || do_writeback1_PR !== b) begin
        errors++; $display("FAIL alu_pr: got %h/%0d/%b required %h/%0d/%b", Data1_PR, writeRegister1_PR, do_writeback1_PR, r, w, b);
      end
    end
  endtask
  task automatic test_mem_access(input logic [5:0] op, input logic st, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] rdata, input int d,
                                 input logic wb, input int exp_freeze);
    logic [4:0]  w = 5'($urandom);
    logic        rd = st ? 1'($urandom) : 1'b1;
    logic [31:0] exp_pr = st ? addr : exp_load(op, addr, rdata);
    int nfreeze = 0;
    set_in({op, 26'($urandom)}, addr, data, w, wb, rd, st);
    #1;
    nfreeze += int'(FREEZE);
    checks++;
    if (FREEZE !== 1'b1 || dmem_req !== 1'b0 || do_writeback1_MEM !== (wb & ~rd)) begin
      errors++; $display("FAIL mem_issue: FREEZE=%b req=%b wbm=%b required 1/0/%b", FREEZE, dmem_req, do_writeback1_MEM, wb & ~rd);
    end
    for (int i = 0; i <= d; i++) begin
      @(negedge CLK);
      nfreeze += int'(FREEZE);
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, st, addr & 32'hFFFF_FFFC, exp_be(op, addr)}) begin
        errors++; $display("FAIL mem_req: req=%b we=%b addr=%h be=%b required 1/%b/%h/%b", dmem_req, dmem_we, dmem_addr, dmem_be, st, addr & 32'hFFFF_FFFC, exp_be(op, addr));
      end
      if (st) begin
        checks++;
        if (dmem_wdata !== exp_wdata(op, data)) begin
          errors++; $display("FAIL mem_wdata: got %h required %h", dmem_wdata, exp_wdata(op, data));
        end
      end
      dmem_ack = (i == d);
      dmem_rdata = (i == d) ? rdata : $urandom;
    end
    @(negedge CLK);
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    checks++;
    if (dmem_req !== 1'b0 || FREEZE !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL mem_done: req=%b FREEZE=%b err=%b required 0/0/0", dmem_req, FREEZE, mem_err);
    end
    @(negedge CLK);
    checks++;
    if (Data1_PR !== exp_pr || writeRegister1_PR !== w || do_writeback1_PR !== (wb & ~st)) begin
      errors++; $display("FAIL mem_pr: got %h/%0d/%b required %h/%0d/%b", Data1_PR, writeRegister1_PR, do_writeback1_PR, exp_pr, w, wb & ~st);
    end
    if (exp_freeze >= 0) begin
      checks++;
      if (nfreeze != exp_freeze) begin
        errors++; $display("FAIL freeze_len: got %0d required %0d", nfreeze, exp_freeze);
      end
    end
    set_nop();
  endtask
  task automatic test_random_mem(input int n);
    logic [5:0] lops[6] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h0F};
    logic [5:0] sops[3] = '{6'h28, 6'h29, 6'h2B};
    for (int i = 0; i < n; i++) begin
      logic st = 1'($urandom);
      logic [5:0] op = st ? sops[$urandom_range(0, 2)] : lops[$urandom_range(0, 5)];
      logic [31:0] addr = $urandom & ~32'(size_of(op) - 1);
      test_mem_access(op, st, addr, $urandom, $urandom, $urandom_range(0, TO - 1), 1'($urandom), $urandom_range(0, TO - 1) + 2 - 0 - 1000);
    end
  endtask
  task automatic test_misaligned(input int n);
    for (int i = 0; i < n; i++) begin
      logic st = (i == 0) ? 1'b0 : 1'($urandom);
      logic half = (i == 0) ? 1'b0 : 1'($urandom);
      logic [5:0] op = half ? (st ? 6'h29 : 6'h21) : (st ? 6'h2B : 6'h23);
      logic [31:0] addr = (i == 0) ? 32'h103 :
                          half ? ($urandom | 32'h1) : (($urandom & ~32'h3) | 32'($urandom_range(1, 3)));
      set_in({op, 26'($urandom)}, addr, $urandom, 5'($urandom), 1'b1, ~st, st);
      #1;
      checks++;
      if (FREEZE !== 1'b0 || dmem_req !== 1'b0) begin
        errors++; $display("FAIL misal_issue: FREEZE=%b req=%b required 0/0", FREEZE, dmem_req);
      end
      @(negedge CLK);
      checks++;
      if (mem_err !== 1'b1 || dmem_req !== 1'b0 || do_writeback1_PR !== 1'b0) begin
        errors++; $display("FAIL misal_err: err=%b req=%b wb=%b required 1/0/0", mem_err, dmem_req, do_writeback1_PR);
      end
      set_nop();
      @(negedge CLK);
      checks++;
      if (mem_err !== 1'b0) begin
        errors++; $display("FAIL misal_pulse: err=%b required 0", mem_err);
      end
    end
  endtask
  task automatic test_timeout();
    set_in({6'h23, 26'($urandom)}, 32'h400, '0, 5'd7, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < TO; i++) begin
      @(negedge CLK);
      checks++;
      if (dmem_req !== 1'b1 || FREEZE !== 1'b1) begin
        errors++; $display("FAIL to_wait%0d: req=%b FREEZE=%b required 1/1", i, dmem_req, FREEZE);
      end
    end
    @(negedge CLK);
    checks++;
    if (dmem_req !== 1'b0 || mem_err !== 1'b1 || FREEZE !== 1'b0) begin
      errors++; $display("FAIL to_abort: req=%b err=%b FREEZE=%b required 0/1/0", dmem_req, mem_err, FREEZE);
    end
    @(negedge CLK);
    checks++;
    if (mem_err !== 1'b0 || do_writeback1_PR !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL to_resume: err=%b wb=%b req=%b required 0/0/0", mem_err, do_writeback1_PR, dmem_req);
    end
    set_nop();
    @(negedge CLK);
  endtask
  task automatic test_reset_mid_wait();
    set_in({6'h23, 26'($urandom)}, 32'h800, '0, 5'd3, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_req: req=%b required 1", dmem_req);
    end
    #1 RESET = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || Data1_PR !== '0 || do_writeback1_PR !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_async: req=%b PR=%h wb=%b err=%b required 0", dmem_req, Data1_PR, do_writeback1_PR, mem_err);
    end
    set_nop();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(negedge CLK);
    dmem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dmem_req !== 1'b0 || FREEZE !== 1'b0 || mem_err !== 1'b0 || Data1_PR !== '0 || do_writeback1_PR !== 1'b0) begin
        errors++; $display("FAIL rst_ack_ignored: req=%b FREEZE=%b err=%b PR=%h wb=%b required all 0", dmem_req, FREEZE, mem_err, Data1_PR, do_writeback1_PR);
      end
      @(negedge CLK);
    end
  endtask
  initial begin
    test_reset();
    test_alu(8);
    test_mem_access(6'h20, 1'b0, 32'h101, $urandom, 32'h1180_7F22, 2, 1'b1, 4);
    test_mem_access(6'h29, 1'b0 | 1'b1, 32'h202, 32'hABCD_BEEF, $urandom, 0, 1'b1, 2);
    test_mem_access(6'h23, 1'b0, 32'h1000, $urandom, $urandom, TO - 1, 1'b1, TO + 1);
    test_random_mem(30);
    test_misaligned(6);
    test_timeout();
    test_alu(4);
    test_reset_mid_wait();
    test_alu(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
